// File: rtl/zx_timebase.sv
// Mains zero-crossing front end: synchronizes and debounces zx_in, qualifies half-cycle
// edges, measures the half-period and spreads 2^TICK_LOG2 phase ticks over each half-cycle.
module zx_timebase #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 64,
  parameter int PER_W       = 20,
  parameter int MIN_PERIOD  = 350000,
  parameter int MAX_PERIOD  = 600000,
  parameter int TICK_LOG2   = 10,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zx_in,
  output logic             zxing,
  output logic             enable,
  output logic [PER_W-1:0] period,
  output logic             locked,
  output logic             polarity
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int VC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [DB_W-1:0]    DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [PER_W-1:0]   MIN_P    = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]   MAX_P    = PER_W'(MAX_PERIOD);
  localparam logic [VC_W-1:0]    VC_MAX   = VC_W'(LOCK_COUNT);
  localparam logic [TICK_LOG2:0] TICK_MAX = {1'b1, {TICK_LOG2{1'b0}}};

  typedef enum logic [1:0] {ST_ACQUIRE, ST_MEASURE, ST_LOCKED} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_polarity;
  logic                   r_pol_d;
  logic [PER_W-1:0]       r_half;
  logic [PER_W-1:0]       r_period;
  logic [PER_W-1:0]       r_tick;
  logic [TICK_LOG2:0]     r_tally;
  logic [VC_W-1:0]        r_valid;
  state_t                 r_state;
  logic                   r_zxing;
  logic                   r_enable;
  logic                   r_locked;

  logic                   w_sync;
  logic                   w_cand;
  logic                   w_timeout;
  logic                   w_first;
  logic                   w_accept;
  logic [PER_W-1:0]       w_shifted;
  logic [PER_W-1:0]       w_interval;
  logic [PER_W-1:0]       w_tick_inc;
  logic [VC_W-1:0]        w_valid_inc;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_cand      = r_polarity ^ r_pol_d;
  // half_cnt saturates at MAX_P, so the upper bound of the window is implicit
  assign w_timeout   = (r_half == MAX_P);
  assign w_first     = w_cand && ((r_state == ST_ACQUIRE) || w_timeout);
  assign w_accept    = w_first || (w_cand && (r_half >= MIN_P));
  assign w_shifted   = r_period >> TICK_LOG2;
  assign w_interval  = (w_shifted == '0) ? PER_W'(1) : w_shifted;
  assign w_tick_inc  = r_tick + 1'b1;
  assign w_valid_inc = (r_valid == VC_MAX) ? r_valid : r_valid + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_db_cnt   <= '0;
      r_polarity <= 1'b0;
      r_pol_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the chain shifts one stage per clock.
      r_sync  <= {r_sync[SYNC_STAGES-2:0], zx_in};
      r_pol_d <= r_polarity;
      if (w_sync == r_polarity) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_polarity <= ~r_polarity;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ACQUIRE;
      r_half   <= '0;
      r_period <= '0;
      r_valid  <= '0;
      r_tick   <= '0;
      r_tally  <= '0;
      r_zxing  <= 1'b0;
      r_enable <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_zxing  <= w_accept;
      r_enable <= 1'b0;

      if (w_accept) begin
        r_half <= PER_W'(1);
      end else if (!w_timeout) begin
        r_half <= r_half + 1'b1;
      end

      // A timeout coinciding with an edge restarts acquisition from that edge
      if (w_first) begin
        r_state  <= ST_MEASURE;
        r_valid  <= '0;
        r_locked <= 1'b0;
      end else if (w_timeout) begin
        r_state  <= ST_ACQUIRE;
        r_valid  <= '0;
        r_locked <= 1'b0;
      end else if (w_accept) begin
        r_period <= r_half;
        r_valid  <= w_valid_inc;
        if (w_valid_inc == VC_MAX) begin
          r_state  <= ST_LOCKED;
          r_locked <= 1'b1;
        end
      end

      if (w_accept) begin
        r_tick  <= '0;
        r_tally <= '0;
      end else if ((r_state == ST_LOCKED) && !w_timeout) begin
        if (w_tick_inc >= w_interval) begin
          r_tick <= '0;
          if (r_tally != TICK_MAX) begin
            r_enable <= 1'b1;
            r_tally  <= r_tally + 1'b1;
          end
        end else begin
          r_tick <= w_tick_inc;
        end
      end
    end
  end

  assign zxing    = r_zxing;
  assign enable   = r_enable;
  assign period   = r_period;
  assign locked   = r_locked;
  assign polarity = r_polarity;

endmodule

// File: tb/tb_zx_timebase.sv
// Self-checking bench for zx_timebase: randomized zx_in waveforms are scored cycle by
// cycle against an event-time reference model built from the half-cycle rules.
module tb_zx_timebase;

  localparam int SYNC       = 2;
  localparam int DEB        = 4;
  localparam int PER_W      = 8;
  localparam int MIN_P      = 80;
  localparam int MAX_P      = 120;
  localparam int TL         = 3;
  localparam int LOCK       = 2;
  localparam int MAXN       = 4096;
  localparam int LAT_POL    = SYNC + DEB;      // edge offset at which polarity flips
  localparam int LAT_ZX     = SYNC + DEB + 1;  // edge offset at which zxing is issued
  localparam int MIN_STABLE = DEB + 2;

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             zx_in;
  logic             zxing;
  logic             enable;
  logic [PER_W-1:0] period;
  logic             locked;
  logic             polarity;

  seg_t segs[$];
  bit   lvl_at [MAXN];
  bit   cand   [MAXN];
  bit   exp_zx [MAXN];
  bit   exp_en [MAXN];
  bit   exp_lk [MAXN];
  bit   exp_pol[MAXN];
  int   exp_per[MAXN];
  int   n_len;

  int n_tests = 0;
  int n_fail  = 0;

  zx_timebase #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE   (DEB),
    .PER_W      (PER_W),
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P),
    .TICK_LOG2  (TL),
    .LOCK_COUNT (LOCK)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .zx_in   (zx_in),
    .zxing   (zxing),
    .enable  (enable),
    .period  (period),
    .locked  (locked),
    .polarity(polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add_seg(input bit l, input int n);
    segs.push_back('{lvl: l, len: n});
  endtask

  // Reference model: stable input runs become candidate edges at fixed latency; acceptance,
  // locking and tick placement follow from elapsed time since the last accepted edge.
  task automatic build_model();
    bit cur = 1'b0;
    bit pol = 1'b0;
    bit acc;
    bit pol_chg[MAXN];
    int s   = 0;
    int st  = 0;  // 0 acquire, 1 measure, 2 locked
    int a   = 0;
    int per = 0;
    int vc  = 0;
    int iv;
    int k;
    for (int i = 0; i < MAXN; i++) begin
      lvl_at[i]  = 1'b0;
      cand[i]    = 1'b0;
      pol_chg[i] = 1'b0;
    end
    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].len; j++) lvl_at[s + j] = segs[i].lvl;
      if (segs[i].lvl != cur && segs[i].len >= MIN_STABLE) begin
        cur = segs[i].lvl;
        pol_chg[s + LAT_POL] = 1'b1;
        cand[s + LAT_ZX]     = 1'b1;
      end
      s += segs[i].len;
    end
    n_len = s;
    for (int e = 0; e < n_len; e++) begin
      if (pol_chg[e]) pol = ~pol;
      exp_pol[e] = pol;
      acc = 1'b0;
      if (cand[e] && (st == 0 || e - a >= MAX_P)) begin
        acc = 1'b1;
        st  = 1;
        vc  = 0;
      end else if (cand[e] && e - a >= MIN_P) begin
        acc = 1'b1;
        per = e - a;
        vc  = (vc < LOCK) ? vc + 1 : LOCK;
        if (vc == LOCK) st = 2;
      end else if (st != 0 && e - a >= MAX_P) begin
        st = 0;
      end
      if (acc) a = e;
      iv = per >> TL;
      if (iv < 1) iv = 1;
      k = e - a;
      exp_en[e]  = (st == 2) && !acc && (k > 0) && (k % iv == 0) && (k / iv <= (1 << TL));
      exp_zx[e]  = acc;
      exp_lk[e]  = (st == 2);
      exp_per[e] = per;
    end
  endtask

  // Index of the 4th tick after the final accepted edge: a point inside a tick train
  function automatic int pick_stop();
    int last_acc = 0;
    int cnt = 0;
    for (int e = 0; e < n_len; e++) if (exp_zx[e]) last_acc = e;
    for (int e = last_acc + 1; e < n_len; e++) begin
      if (exp_en[e]) begin
        cnt++;
        if (cnt == 4) return e;
      end
    end
    return n_len - 1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_zxing"},    zxing,    0);
    check({tag, "_enable"},   enable,   0);
    check({tag, "_period"},   period,   0);
    check({tag, "_locked"},   locked,   0);
    check({tag, "_polarity"}, polarity, 0);
  endtask

  task automatic reset_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all_zero($sformatf("%s%0d", tag, i));
      zx_in = ~zx_in;
    end
  endtask

  // Called at a negedge with rst_n low; releases reset and scores every cycle up to stop
  task automatic run_episode(input string tag, input int stop, output int edges_to_lock);
    bit seen_lock = 1'b0;
    int nz = 0;
    zx_in = lvl_at[0];
    rst_n = 1'b1;
    for (int e = 0; e <= stop; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_zxing@%0d", tag, e),    zxing,    exp_zx[e]);
      check($sformatf("%s_enable@%0d", tag, e),   enable,   exp_en[e]);
      check($sformatf("%s_locked@%0d", tag, e),   locked,   exp_lk[e]);
      check($sformatf("%s_period@%0d", tag, e),   period,   exp_per[e]);
      check($sformatf("%s_polarity@%0d", tag, e), polarity, exp_pol[e]);
      if (!seen_lock) begin
        if (zxing) nz++;
        if (locked) seen_lock = 1'b1;
      end
      if (e + 1 < n_len) zx_in = lvl_at[e + 1];
    end
    edges_to_lock = nz;
  endtask

  initial begin
    bit l;
    int g;
    int h;
    int x;
    int stop;
    int etl;

    rst_n = 1'b0;
    zx_in = 1'b0;
    reset_hold(4, "rst_hold");

    // Episode 1: lock at 100, random periods, glitches, blanking excursions, timeout, relock
    segs.delete();
    l = 1'b1;
    repeat (6) begin add_seg(l, 100); l = ~l; end
    repeat (3) begin add_seg(l, $urandom_range(85, 115)); l = ~l; end
    repeat (2) begin
      g = $urandom_range(20, 60);
      h = $urandom_range(90, 110);
      add_seg(l, g); add_seg(~l, 3); add_seg(l, h - g - 3);
      l = ~l;
    end
    repeat (2) begin
      g = $urandom_range(35, 55);
      x = $urandom_range(8, 14);
      add_seg(l, g); add_seg(~l, x); add_seg(l, 100 - g - x);
      l = ~l;
    end
    add_seg(l, 200 + $urandom_range(0, 40)); l = ~l;
    repeat (6) begin add_seg(l, $urandom_range(90, 110)); l = ~l; end
    build_model();
    stop = pick_stop();
    run_episode("ep1", stop, etl);
    check("ep1_edges_to_lock", etl, LOCK + 1);

    // Asynchronous reset in the middle of a tick train
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    reset_hold(3, "midrst_hold");

    // Episode 2: relock from a random starting level
    segs.delete();
    l = 1'($urandom_range(0, 1));
    add_seg(l, $urandom_range(85, 115)); l = ~l;
    repeat (6) begin add_seg(l, $urandom_range(85, 115)); l = ~l; end
    build_model();
    run_episode("ep2", n_len - 1, etl);
    check("ep2_edges_to_lock", etl, LOCK + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
